// File: rtl/alu_issue_ctrl.sv
// Issues one operation to the ALU over the en/alu_done handshake and returns the captured
// outputs on a valid/ready response port. Every wait on the ALU is bounded by TIMEOUT.
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_hi,
    output logic [DATA_W-1:0] rsp_lo,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_srcA,
    output logic [DATA_W-1:0] alu_srcB,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic [DATA_W-1:0] alu_lo,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_done
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [TW-1:0]     timer, timer_next;
    logic              alu_en_next;
    logic [OP_W-1:0]   alu_control_next;
    logic [DATA_W-1:0] alu_srcA_next, alu_srcB_next;
    logic              rsp_valid_next;
    logic [DATA_W-1:0] rsp_result_next, rsp_hi_next, rsp_lo_next;
    logic              rsp_overflow_next, rsp_zero_next, rsp_timeout_next;

    // A stale alu_done from a previous op (or from before reset) blocks acceptance.
    assign req_ready = (state == IDLE) && !alu_done;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            alu_en       <= 1'b0;
            alu_control  <= '0;
            alu_srcA     <= '0;
            alu_srcB     <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_hi       <= '0;
            rsp_lo       <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            alu_en       <= alu_en_next;
            alu_control  <= alu_control_next;
            alu_srcA     <= alu_srcA_next;
            alu_srcB     <= alu_srcB_next;
            rsp_valid    <= rsp_valid_next;
            rsp_result   <= rsp_result_next;
            rsp_hi       <= rsp_hi_next;
            rsp_lo       <= rsp_lo_next;
            rsp_overflow <= rsp_overflow_next;
            rsp_zero     <= rsp_zero_next;
            rsp_timeout  <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next        = state;
        timer_next        = timer;
        alu_en_next       = alu_en;
        alu_control_next  = alu_control;
        alu_srcA_next     = alu_srcA;
        alu_srcB_next     = alu_srcB;
        rsp_valid_next    = rsp_valid;
        rsp_result_next   = rsp_result;
        rsp_hi_next       = rsp_hi;
        rsp_lo_next       = rsp_lo;
        rsp_overflow_next = rsp_overflow;
        rsp_zero_next     = rsp_zero;
        rsp_timeout_next  = rsp_timeout;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    alu_control_next = req_op;
                    alu_srcA_next    = req_a;
                    alu_srcB_next    = req_b;
                    alu_en_next      = 1'b1;
                    timer_next       = '0;
                    state_next       = RUN;
                end
            end
            // alu_done is checked before the timer so a completion on the last cycle still wins.
            RUN: begin
                if (alu_done) begin
                    rsp_result_next   = alu_result;
                    rsp_hi_next       = alu_hi;
                    rsp_lo_next       = alu_lo;
                    rsp_overflow_next = alu_overflow;
                    rsp_zero_next     = alu_zero;
                    rsp_timeout_next  = 1'b0;
                    alu_en_next       = 1'b0;
                    timer_next        = '0;
                    state_next        = DRAIN;
                end else if (timer == TIMER_MAX) begin
                    rsp_result_next   = '0;
                    rsp_hi_next       = '0;
                    rsp_lo_next       = '0;
                    rsp_overflow_next = 1'b0;
                    rsp_zero_next     = 1'b0;
                    rsp_timeout_next  = 1'b1;
                    alu_en_next       = 1'b0;
                    timer_next        = '0;
                    state_next        = DRAIN;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            DRAIN: begin
                if (!alu_done) begin
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end else if (timer == TIMER_MAX) begin
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU model with stub modes, a vector table
// for nominal ops and hand-written sequences for timeout, reset and throughput corners.
module tb_alu_issue_ctrl;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int TIMEOUT = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_MULT = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [OP_W-1:0]   req_op = '0;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_result, rsp_hi, rsp_lo;
    logic              rsp_overflow, rsp_zero, rsp_timeout, busy;
    logic              alu_en;
    logic [OP_W-1:0]   alu_control;
    logic [DATA_W-1:0] alu_srcA, alu_srcB;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] alu_hi = '0;
    logic [DATA_W-1:0] alu_lo = '0;
    logic              alu_overflow = 1'b0;
    logic              alu_zero = 1'b0;
    logic              alu_done;
    logic              done_q = 1'b0;

    // 0 = nominal ALU, 1 = done never rises, 2 = done stuck high
    int stub_mode = 0;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    alu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_overflow(rsp_overflow),
        .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout), .busy(busy),
        .alu_en(alu_en), .alu_control(alu_control), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: done follows en by one cycle; hi/lo change only for MULT/DIV.
    always @(posedge clk) begin
        logic [DATA_W-1:0] r;
        logic [63:0]       p;
        done_q <= alu_en;
        if (alu_en) begin
            r = '0;
            alu_overflow <= 1'b0;
            case (alu_control)
                OP_ADD: r = alu_srcA + alu_srcB;
                OP_SUB: r = alu_srcA - alu_srcB;
                OP_AND: r = alu_srcA & alu_srcB;
                OP_OR:  r = alu_srcA | alu_srcB;
                OP_MULT: begin
                    p = {32'd0, alu_srcA} * {32'd0, alu_srcB};
                    alu_hi <= p[63:32];
                    alu_lo <= p[31:0];
                end
                OP_DIV: begin
                    if (alu_srcB == 0) begin
                        alu_overflow <= 1'b1;
                        alu_hi <= '0;
                        alu_lo <= '0;
                    end else begin
                        alu_hi <= alu_srcA % alu_srcB;
                        alu_lo <= alu_srcA / alu_srcB;
                    end
                end
                default: r = '0;
            endcase
            alu_result <= r;
            alu_zero   <= (r == 0);
        end
    end

    assign alu_done = (stub_mode == 2) ? 1'b1 : (stub_mode == 1) ? 1'b0 : done_q;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] exp_res;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Presents a request from a negedge and returns the cycle stamp of the accepting edge.
    task automatic issueReq(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int acc);
        int guard = 0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_wait_bound", guard < 50, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic waitRsp(output int seen);
        int guard = 0;
        while (!rsp_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rsp_wait_bound", guard < 60, 1);
        seen = cyc;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag, output int acc);
        int seen;
        rsp_ready = (v.hold == 0);
        issueReq(v.op, v.a, v.b, acc);
        checkOutput({tag, "_busy"}, busy, 1);
        waitRsp(seen);
        checkOutput({tag, "_latency"}, seen - acc, 4);
        checkOutput({tag, "_result"}, rsp_result, v.exp_res);
        checkOutput({tag, "_hi"}, rsp_hi, v.exp_hi);
        checkOutput({tag, "_lo"}, rsp_lo, v.exp_lo);
        checkOutput({tag, "_overflow"}, rsp_overflow, v.exp_ovf);
        checkOutput({tag, "_zero"}, rsp_zero, v.exp_zero);
        checkOutput({tag, "_timeout"}, rsp_timeout, 0);
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, rsp_valid, 1);
            checkOutput({tag, "_hold_result"}, rsp_result, v.exp_res);
            checkOutput({tag, "_hold_zero"}, rsp_zero, v.exp_zero);
            checkOutput({tag, "_hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_rsp_cleared"}, rsp_valid, 0);
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int acc, acc2, seen, en_cycles;

        vecs[0] = '{OP_ADD,  32'd5,        32'd7,        0, 32'd12,         32'd0, 32'd0,          1'b0, 1'b0};
        vecs[1] = '{OP_SUB,  32'd3,        32'd3,        3, 32'd0,          32'd0, 32'd0,          1'b0, 1'b1};
        vecs[2] = '{OP_MULT, 32'h0001_0000, 32'h0001_0000, 0, 32'd0,        32'd1, 32'd0,          1'b0, 1'b1};
        vecs[3] = '{OP_DIV,  32'd7,        32'd0,        0, 32'd0,          32'd0, 32'd0,          1'b1, 1'b1};
        vecs[4] = '{OP_OR,   32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 32'd0, 32'd0,        1'b0, 1'b0};
        vecs[5] = '{4'd12,   32'd9,        32'd9,        0, 32'd0,          32'd0, 32'd0,          1'b0, 1'b1};
        vecs[6] = '{OP_MULT, 32'hFFFF_FFFF, 32'd2,       0, 32'd0,          32'd1, 32'hFFFF_FFFE,  1'b0, 1'b1};
        vecs[7] = '{OP_DIV,  32'd100,      32'd7,        2, 32'd0,          32'd2, 32'd14,         1'b0, 1'b1};
        vecs[8] = '{OP_SUB,  32'd10,       32'd3,        0, 32'd7,          32'd2, 32'd14,         1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_alu_en", alu_en, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rsp_result", rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i), acc);
        end

        // Hung ALU: en must stay up for exactly TIMEOUT cycles, then a zeroed timeout response.
        stub_mode = 1;
        rsp_ready = 1'b0;
        issueReq(OP_ADD, 32'd1, 32'd2, acc);
        en_cycles = 0;
        while (alu_en && en_cycles < 40) begin
            en_cycles++;
            @(negedge clk);
        end
        checkOutput("to_en_cycles", en_cycles, TIMEOUT);
        waitRsp(seen);
        checkOutput("to_latency", seen - acc, TIMEOUT + 1);
        checkOutput("to_flag", rsp_timeout, 1);
        checkOutput("to_result", rsp_result, 0);
        checkOutput("to_hi", rsp_hi, 0);
        checkOutput("to_lo", rsp_lo, 0);
        checkOutput("to_overflow", rsp_overflow, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("to_rsp_cleared", rsp_valid, 0);

        // Reset in RUN drops outputs without a clock; stuck-high done then blocks acceptance.
        issueReq(OP_ADD, 32'd4, 32'd4, acc);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_en_before", alu_en, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_alu_en", alu_en, 0);
        checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
        checkOutput("rst_mid_busy", busy, 0);
        stub_mode = 2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_stale_done_req_ready", req_ready, 0);
        end
        stub_mode = 0;
        #1;
        checkOutput("rst_done_low_req_ready", req_ready, 1);
        @(negedge clk);

        // Back-to-back ops with rsp_ready held high: one accept every 6 cycles.
        applyStimulus('{OP_ADD, 32'd1, 32'd1, 0, 32'd2, 32'd2, 32'd14, 1'b0, 1'b0}, "b2b_add", acc);
        applyStimulus('{OP_OR, 32'h0000_00F0, 32'h0000_000F, 0, 32'h0000_00FF, 32'd2, 32'd14, 1'b0, 1'b0},
                      "b2b_or", acc2);
        checkOutput("b2b_accept_gap", acc2 - acc, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
